// File: rtl/ram_arbiter.sv
// Shares one single-port synchronous RAM between a CPU requester and a loader requester.
// Latency: req seen in IDLE cycle n -> RAM enable n+1 -> ack + read data n+3 -> IDLE n+4.
// Backpressure: requests are sampled only in IDLE. CPU has priority. The loader is forced in after MAX_CPU_STREAK contested CPU wins.
//
// Ports:
//   clk, reset             clock and asynchronous active-low reset
//   cpu_* / ldr_*          level request, op, address and write data in; held read data and one-cycle ack out
//   ram_*                  registered enables/address/write data to the RAM, and its synchronous read data back
//   busy, owner            transaction in flight; owner 0 = CPU, 1 = loader
module ram_arbiter #(
    parameter int ADDR_W         = 12,
    parameter int DATA_W         = 16,
    parameter int MAX_CPU_STREAK = 4
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              cpu_req,
    input  logic              cpu_we,
    input  logic [ADDR_W-1:0] cpu_addr,
    input  logic [DATA_W-1:0] cpu_wdata,
    output logic [DATA_W-1:0] cpu_rdata,
    output logic              cpu_ack,
    input  logic              ldr_req,
    input  logic              ldr_we,
    input  logic [ADDR_W-1:0] ldr_addr,
    input  logic [DATA_W-1:0] ldr_wdata,
    output logic [DATA_W-1:0] ldr_rdata,
    output logic              ldr_ack,
    output logic              ram_r_en,
    output logic              ram_w_en,
    output logic [ADDR_W-1:0] ram_addr,
    output logic [DATA_W-1:0] ram_w_data,
    input  logic [DATA_W-1:0] ram_r_data,
    output logic              busy,
    output logic              owner
);

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_ISSUE   = 2'd1,
        S_CAPTURE = 2'd2,
        S_ACK     = 2'd3
    } state_t;

    localparam logic [3:0] STREAK_MAX = 4'(MAX_CPU_STREAK);

    state_t     state;
    state_t     state_nxt;
    logic       grant_vld;
    logic       grant_ldr;
    logic       op_we;
    logic [3:0] streak;

    // Next-state and grant decision. The loader wins a contested cycle only
    // once the CPU has used up its streak allowance.
    always_comb begin
        state_nxt = state;
        grant_vld = 1'b0;
        grant_ldr = 1'b0;
        case (state)
            S_IDLE: begin
                if (cpu_req || ldr_req) begin
                    grant_vld = 1'b1;
                    grant_ldr = ldr_req && (!cpu_req || (streak == STREAK_MAX));
                    state_nxt = S_ISSUE;
                end
            end
            S_ISSUE:   state_nxt = S_CAPTURE;
            S_CAPTURE: state_nxt = S_ACK;
            S_ACK:     state_nxt = S_IDLE;
            default:   state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Datapath. Enables and acks are single-cycle pulses, so they default low
    // every cycle and are raised only on the edge that enters ISSUE or ACK.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            ram_r_en   <= 1'b0;
            ram_w_en   <= 1'b0;
            ram_addr   <= '0;
            ram_w_data <= '0;
            cpu_rdata  <= '0;
            ldr_rdata  <= '0;
            cpu_ack    <= 1'b0;
            ldr_ack    <= 1'b0;
            owner      <= 1'b0;
            op_we      <= 1'b0;
            streak     <= '0;
        end else begin
            ram_r_en <= 1'b0;
            ram_w_en <= 1'b0;
            cpu_ack  <= 1'b0;
            ldr_ack  <= 1'b0;

            if (grant_vld) begin
                owner      <= grant_ldr;
                op_we      <= grant_ldr ? ldr_we    : cpu_we;
                ram_addr   <= grant_ldr ? ldr_addr  : cpu_addr;
                ram_w_data <= grant_ldr ? ldr_wdata : cpu_wdata;
                ram_w_en   <= grant_ldr ? ldr_we    : cpu_we;
                ram_r_en   <= grant_ldr ? !ldr_we   : !cpu_we;
                // Streak counts only CPU wins that made the loader wait.
                if (grant_ldr || !ldr_req) begin
                    streak <= '0;
                end else if (streak != STREAK_MAX) begin
                    streak <= streak + 4'd1;
                end
            end

            // RAM read data is valid during CAPTURE (one cycle after r_en).
            if (state == S_CAPTURE) begin
                if (!op_we) begin
                    if (owner) begin
                        ldr_rdata <= ram_r_data;
                    end else begin
                        cpu_rdata <= ram_r_data;
                    end
                end
                cpu_ack <= !owner;
                ldr_ack <= owner;
            end
        end
    end

    assign busy = (state != S_IDLE);

endmodule

// File: tb/tb_ram_arbiter.sv
// Scoreboard bench for ram_arbiter with a behavioural 4096x16 synchronous RAM.
// Stimulus pushes expected transactions; a negedge monitor checks each ack.
// Ack order, owner, RAM enable count/address/data and read data are compared per transaction.
module tb_ram_arbiter;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        cpu_req = 1'b0, cpu_we = 1'b0;
    logic [11:0] cpu_addr = '0;
    logic [15:0] cpu_wdata = '0;
    logic [15:0] cpu_rdata;
    logic        cpu_ack;
    logic        ldr_req = 1'b0, ldr_we = 1'b0;
    logic [11:0] ldr_addr = '0;
    logic [15:0] ldr_wdata = '0;
    logic [15:0] ldr_rdata;
    logic        ldr_ack;
    logic        ram_r_en, ram_w_en;
    logic [11:0] ram_addr;
    logic [15:0] ram_w_data;
    logic [15:0] ram_r_data;
    logic        busy, owner;

    int checks = 0;
    int failures = 0;
    int cyc = 0;

    ram_arbiter #(.ADDR_W(12), .DATA_W(16), .MAX_CPU_STREAK(4)) dut (
        .clk(clk), .reset(reset),
        .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
        .cpu_rdata(cpu_rdata), .cpu_ack(cpu_ack),
        .ldr_req(ldr_req), .ldr_we(ldr_we), .ldr_addr(ldr_addr), .ldr_wdata(ldr_wdata),
        .ldr_rdata(ldr_rdata), .ldr_ack(ldr_ack),
        .ram_r_en(ram_r_en), .ram_w_en(ram_w_en), .ram_addr(ram_addr),
        .ram_w_data(ram_w_data), .ram_r_data(ram_r_data),
        .busy(busy), .owner(owner)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc++;

    // Behavioural RAM: synchronous read, data valid the cycle after r_en.
    logic [15:0] mem [0:4095];
    always @(posedge clk) begin
        if (ram_w_en) mem[ram_addr] <= ram_w_data;
        if (ram_r_en) ram_r_data <= mem[ram_addr];
    end

    typedef struct {
        bit          port;   // 0 = CPU, 1 = loader
        bit          we;
        logic [11:0] addr;
        logic [15:0] wdata;
        logic [15:0] rdata;
    } exp_t;

    exp_t exp_q[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, req, cyc);
        end
    endtask

    task automatic expect_op(input bit port, input bit we, input logic [11:0] addr,
                             input logic [15:0] wdata, input logic [15:0] rdata);
        exp_t x;
        x.port = port; x.we = we; x.addr = addr; x.wdata = wdata; x.rdata = rdata;
        exp_q.push_back(x);
    endtask

    task automatic drive(input bit port, input bit req, input bit we,
                         input logic [11:0] addr, input logic [15:0] wdata);
        if (port) begin
            ldr_req = req; ldr_we = we; ldr_addr = addr; ldr_wdata = wdata;
        end else begin
            cpu_req = req; cpu_we = we; cpu_addr = addr; cpu_wdata = wdata;
        end
    endtask

    // Waits (bounded) for the given port's ack, sampled at negedge.
    task automatic wait_ack(input bit port, output bit got);
        got = 1'b0;
        for (int i = 0; i < 20 && !got; i++) begin
            @(negedge clk);
            if (port ? ldr_ack : cpu_ack) got = 1'b1;
        end
        if (!got) begin
            checks++;
            failures++;
            $display("FAIL ack_timeout: port %0d got no ack within 20 cycles", port);
        end
    endtask

    task automatic op(input bit port, input bit we, input logic [11:0] addr,
                      input logic [15:0] wdata, input logic [15:0] rdata, input bit lat);
        int t0;
        bit got;
        expect_op(port, we, addr, wdata, rdata);
        @(negedge clk);
        drive(port, 1'b1, we, addr, wdata);
        t0 = cyc;
        wait_ack(port, got);
        if (got && lat) check("ack_latency", cyc - t0, 3);
        drive(port, 1'b0, we, addr, wdata);
    endtask

    // Monitor: tracks RAM enables and pops/compares an expectation on every ack.
    int          en_cnt = 0;
    logic        last_we = 1'b0;
    logic [11:0] last_addr = '0;
    logic [15:0] last_wdata = '0;
    exp_t        mon_e;

    always @(negedge clk) begin
        if (!reset) begin
            en_cnt = 0;
        end else begin
            if (ram_r_en || ram_w_en) begin
                check("single_enable", {31'd0, ram_r_en && ram_w_en}, 0);
                en_cnt++;
                last_we = ram_w_en;
                last_addr = ram_addr;
                last_wdata = ram_w_data;
            end
            if (cpu_ack || ldr_ack) begin
                check("one_ack", {31'd0, cpu_ack && ldr_ack}, 0);
                if (exp_q.size() == 0) begin
                    checks++;
                    failures++;
                    $display("FAIL unexpected_ack: cpu_ack=%0d ldr_ack=%0d, expected none", cpu_ack, ldr_ack);
                end else begin
                    mon_e = exp_q.pop_front();
                    check("ack_port", {31'd0, ldr_ack}, {31'd0, mon_e.port});
                    check("owner", {31'd0, owner}, {31'd0, mon_e.port});
                    check("enable_count", en_cnt, 1);
                    check("op_type", {31'd0, last_we}, {31'd0, mon_e.we});
                    check("ram_addr", {20'd0, last_addr}, {20'd0, mon_e.addr});
                    if (mon_e.we)
                        check("ram_w_data", {16'd0, last_wdata}, {16'd0, mon_e.wdata});
                    else
                        check("rdata", {16'd0, mon_e.port ? ldr_rdata : cpu_rdata}, {16'd0, mon_e.rdata});
                end
                en_cnt = 0;
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures + 1);
        $fatal(1, "watchdog");
    end

    initial begin
        bit got;
        int n;
        int acks;

        for (int i = 0; i < 4096; i++) mem[i] = 16'h0000;
        mem[12'h001] = 16'h0F0F;
        mem[12'h020] = 16'h5555;

        // Reset held with both requesters asking for reads.
        drive(0, 1'b1, 1'b0, 12'h000, 16'h0000);
        drive(1, 1'b1, 1'b0, 12'h001, 16'h0000);
        expect_op(0, 1'b0, 12'h000, 16'h0000, 16'h0000);
        expect_op(1, 1'b0, 12'h001, 16'h0000, 16'h0F0F);
        repeat (3) @(negedge clk);
        check("rst_enables", {30'd0, ram_r_en, ram_w_en}, 0);
        check("rst_ack_busy_owner", {28'd0, cpu_ack, ldr_ack, busy, owner}, 0);
        check("rst_ram_addr", {20'd0, ram_addr}, 0);
        check("rst_ram_w_data", {16'd0, ram_w_data}, 0);
        check("rst_rdata", {cpu_rdata, ldr_rdata}, 0);

        // Release: CPU is granted on the first edge.
        reset = 1'b1;
        @(negedge clk);
        check("first_grant_busy", {31'd0, busy}, 1);
        check("first_grant_owner", {31'd0, owner}, 0);
        check("first_grant_r_en", {31'd0, ram_r_en}, 1);
        wait_ack(0, got);
        cpu_req = 1'b0;
        wait_ack(1, got);
        ldr_req = 1'b0;

        // CPU write then read-back.
        op(0, 1'b1, 12'h012, 16'hBEEF, 16'h0000, 1'b1);
        op(0, 1'b0, 12'h012, 16'h0000, 16'hBEEF, 1'b1);

        // Loader only, at the top address.
        op(1, 1'b1, 12'hFFF, 16'h1234, 16'h0000, 1'b0);
        op(1, 1'b0, 12'hFFF, 16'h0000, 16'h1234, 1'b1);
        check("cpu_rdata_held", {16'd0, cpu_rdata}, 32'h0000BEEF);

        // Contention: both held for 10 transactions -> C,C,C,C,L,C,C,C,C,L.
        for (int i = 0; i < 10; i++) begin
            if (i % 5 == 4) expect_op(1, 1'b0, 12'hFFF, 16'h0000, 16'h1234);
            else            expect_op(0, 1'b0, 12'h012, 16'h0000, 16'hBEEF);
        end
        @(negedge clk);
        drive(0, 1'b1, 1'b0, 12'h012, 16'h0000);
        drive(1, 1'b1, 1'b0, 12'hFFF, 16'h0000);
        n = 0;
        for (int k = 0; k < 100 && n < 10; k++) begin
            @(negedge clk);
            if (cpu_ack || ldr_ack) n++;
        end
        cpu_req = 1'b0;
        ldr_req = 1'b0;
        check("contention_ack_count", n, 10);

        // Reset during ISSUE of a CPU write: no write, no ack.
        @(negedge clk);
        drive(0, 1'b1, 1'b1, 12'h020, 16'hAAAA);
        @(posedge clk);
        #2;
        check("issue_w_en", {31'd0, ram_w_en}, 1);
        reset = 1'b0;
        cpu_req = 1'b0;
        #1;
        check("mid_reset_w_en", {31'd0, ram_w_en}, 0);
        check("mid_reset_busy", {31'd0, busy}, 0);
        check("mid_reset_rdata", {16'd0, cpu_rdata}, 0);
        acks = 0;
        repeat (2) @(negedge clk);
        reset = 1'b1;
        repeat (6) begin
            @(negedge clk);
            if (cpu_ack || ldr_ack) acks++;
        end
        check("no_ack_after_reset", acks, 0);
        op(0, 1'b0, 12'h020, 16'h0000, 16'h5555, 1'b1);

        // Late drop: CPU drops req in CAPTURE; the access still completes.
        expect_op(0, 1'b0, 12'h012, 16'h0000, 16'hBEEF);
        @(negedge clk);
        drive(0, 1'b1, 1'b0, 12'h012, 16'h0000);
        @(posedge clk);
        @(posedge clk);
        #1;
        cpu_req = 1'b0;
        wait_ack(0, got);
        @(negedge clk);
        check("late_drop_ack_once", {31'd0, cpu_ack}, 0);
        check("late_drop_idle", {31'd0, busy}, 0);

        repeat (4) @(negedge clk);
        check("scoreboard_drained", exp_q.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/ram_arbiter.md
# ram_arbiter

Two-port arbiter that shares the single-port 4096 x 16 `ram` between the CPU memory path (MAR/MDR) and a loader/debug requester, e.g. a program loader that fills RAM. It sits between both requesters and the `ram` instance, on the same `clk` domain as the rest of the datapath. CPU has fixed priority with a bounded-starvation guarantee for the loader. Each access is a fixed four-cycle request/acknowledge transaction.

## Interface
- `ADDR_W`, 12, RAM address width
- `DATA_W`, 16, RAM word width
- `MAX_CPU_STREAK`, 4, consecutive contested CPU grants allowed before the loader is forced a grant (range 1..15)

- `clk`  input  1  datapath clock; all state changes on rising edge
- `reset`  input  1  asynchronous, active-low reset
- `cpu_req`  input  1  CPU access request (level)
- `cpu_we`  input  1  1 = write, 0 = read; sampled with `cpu_req`
- `cpu_addr`  input  ADDR_W  CPU address
- `cpu_wdata`  input  DATA_W  CPU write data
- `cpu_rdata`  output  DATA_W  CPU read data, held between reads
- `cpu_ack`  output  1  one-cycle completion pulse to CPU
- `ldr_req`, `ldr_we`, `ldr_addr`, `ldr_wdata`  input  1/1/ADDR_W/DATA_W  loader request, same meaning as CPU
- `ldr_rdata`  output  DATA_W  loader read data, held between reads
- `ldr_ack`  output  1  one-cycle completion pulse to loader
- `ram_r_en`  output  1  to `ram.r_en`
- `ram_w_en`  output  1  to `ram.w_en`
- `ram_addr`  output  ADDR_W  to `ram.addr`
- `ram_w_data`  output  DATA_W  to `ram.w_data`
- `ram_r_data`  input  DATA_W  from `ram.r_data` (synchronous read, valid the cycle after `r_en`)
- `busy`  output  1  1 whenever state is not IDLE
- `owner`  output  1  0 = CPU, 1 = loader; meaningful while `busy`

## Operation
- States: IDLE -> ISSUE -> CAPTURE -> ACK -> IDLE. No other transitions.
- IDLE: requests are sampled only here. If any `*_req` is high, pick a winner and latch its `we`, `addr`, `wdata` into `ram_addr`/`ram_w_data` and the internal op bit. Set `owner`. Go to ISSUE. Otherwise stay in IDLE.
- ISSUE: drive exactly one of `ram_r_en`/`ram_w_en` high for exactly this cycle. Both are registered outputs.
- CAPTURE: for a read, load `ram_r_data` into the winner's `*_rdata` register on the exiting edge. For a write, `*_rdata` is unchanged.
- ACK: the winner's `*_ack` is high for this single cycle. The other ack stays 0.
- Arbitration:
  - Only `cpu_req` high -> CPU wins.
  - Only `ldr_req` high -> loader wins.
  - Both high -> CPU wins, unless `streak == MAX_CPU_STREAK`, in which case the loader wins.
- `streak` is a 4-bit counter:
  - Increments on a CPU grant while `ldr_req` is high.
  - Clears on any loader grant, and on a CPU grant while `ldr_req` is low.
  - Saturates at `MAX_CPU_STREAK`.
- Protocol:
  - The requester holds `req`, `we`, `addr`, `wdata` stable from assertion until its ack.
  - `req` still high in the cycle after the ack is a new request.
  - Dropping `req` after the grant does not abort the access: it completes and the ack still pulses.
- `ram_addr` and `ram_w_data` hold their last value after an access.

## Timing
- Reset values:
  - State IDLE.
  - `ram_r_en`, `ram_w_en`, `cpu_ack`, `ldr_ack`, `busy`, `owner` = 0.
  - `ram_addr`, `ram_w_data`, `cpu_rdata`, `ldr_rdata`, `streak` = 0.
- Latency: `req` high in IDLE cycle n -> RAM enable in cycle n+1 -> ack and valid rdata in cycle n+3 -> IDLE in cycle n+4. Throughput is one access per 4 cycles.
- Back-to-back: a requester holding `req` through cycle n+4 is re-granted in that IDLE cycle, subject to arbitration.
- Reset asserted mid-transaction: all registers clear immediately (asynchronous) and the transaction is abandoned with no ack.
  - If reset lands in ISSUE before the edge, `ram_w_en` is already 0 at the edge, so no write occurs.
- Reset release: first grant is possible in the first clock cycle after `reset` goes high.
- Address wrap is not applicable: addresses pass through unmodified, and the full 0..4095 range is legal.

## Test plan
- Reset: hold `reset`=0 with both reqs high -> all outputs 0, no RAM enable. Release -> CPU granted first, `owner`=0.
- CPU write/read: CPU writes 0xBEEF to 0x012, then reads 0x012.
  - Each access takes 4 cycles.
  - `ram_w_en` is high exactly 1 cycle with `ram_addr`=0x012.
  - `cpu_ack` pulses in cycle n+3.
  - `cpu_rdata`=0xBEEF at that ack.
- Loader only: loader writes 0x1234 to 0xFFF, then reads it -> `ldr_ack` pulses, `ldr_rdata`=0x1234, `cpu_ack` never asserts, `cpu_rdata` unchanged.
- Contention: both reqs held continuously with `MAX_CPU_STREAK`=4 -> grant sequence C,C,C,C,L repeating. The loader never waits more than 5 transactions.
- Reset mid-write: assert `reset` during ISSUE of a CPU write of 0xAAAA to 0x020 (RAM holds 0x5555) -> no ack. A subsequent read of 0x020 returns 0x5555.
- Late drop: CPU drops `cpu_req` in CAPTURE -> access completes, `cpu_ack` still pulses once, arbiter returns to IDLE with `busy`=0.
